// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: mem_size codes (same as the data memory),
// FSM state type and the default core bus width.
package load_store_unit_pkg;

    localparam int BUS_WIDTH_DEFAULT = 32;

    localparam logic [1:0] BYTE      = 2'b00;
    localparam logic [1:0] HALF_WORD = 2'b01;
    localparam logic [1:0] WORD      = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DONE = 2'b10,
        ERR  = 2'b11
    } lsu_state_t;

    // Index of the final byte lane for a given access size.
    function automatic logic [1:0] last_idx(input logic [1:0] size);
        case (size)
            WORD:      return 2'd3;
            HALF_WORD: return 2'd1;
            default:   return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_extend.sv
// Load result extension: sign- or zero-extends half and byte loads; words pass through.
module lsu_extend
    import load_store_unit_pkg::*;
#(
    parameter int W = BUS_WIDTH_DEFAULT
) (
    input  logic [W-1:0] raw,
    input  logic [1:0]   mem_size,
    input  logic         sz_ex,
    output logic [W-1:0] ext
);

    always_comb begin
        case (mem_size)
            HALF_WORD: ext = {{(W-16){sz_ex & raw[15]}}, raw[15:0]};
            BYTE:      ext = {{(W-8){sz_ex & raw[7]}}, raw[7:0]};
            default:   ext = raw;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Byte-serial load/store unit: splits core word/half/byte accesses into little-endian byte
// transfers. Build option LSU_ALIGN_CHECK_EN rejects misaligned half/word accesses.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int BUS_WIDTH   = BUS_WIDTH_DEFAULT,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 is_store,
    input  logic [BUS_WIDTH-1:0] address,
    input  logic [BUS_WIDTH-1:0] wdata,
    input  logic [1:0]           mem_size,
    input  logic                 sz_ex,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [BUS_WIDTH-1:0] rdata,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [BUS_WIDTH-1:0] mem_addr,
    output logic [7:0]           mem_wdata,
    input  logic [7:0]           mem_rdata,
    input  logic                 mem_ack,
    output lsu_state_t           state_dbg
);

    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

    lsu_state_t           state_q, state_d;
    logic [BUS_WIDTH-1:0] addr_q, wdata_q, raw_q, rdata_q;
    logic [BUS_WIDTH-1:0] raw_merged, ext_data;
    logic [1:0]           size_q, idx_q, idx_d;
    logic                 store_q, sx_q;
    logic [TW-1:0]        tmo_q, tmo_d;
    logic                 capture, load_done, misaligned, reject;

`ifdef LSU_ALIGN_CHECK_EN
    assign misaligned = ((mem_size == HALF_WORD) && address[0]) ||
                        ((mem_size == WORD) && (address[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif
    assign reject = (mem_size == 2'b11) || misaligned;

    always_comb begin
        raw_merged = raw_q;
        raw_merged[{idx_q, 3'b000} +: 8] = mem_rdata;
    end

    lsu_extend #(.W(BUS_WIDTH)) u_extend (
        .raw      (raw_merged),
        .mem_size (size_q),
        .sz_ex    (sx_q),
        .ext      (ext_data)
    );

    // Memory handshake: a byte moves on any clock edge where mem_req && mem_ack; mem_req,
    // mem_addr and mem_wdata stay stable while waiting for mem_ack.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        tmo_d     = tmo_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        done      = 1'b0;
        err       = 1'b0;
        capture   = 1'b0;
        load_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = reject ? ERR : REQ;
                    idx_d   = 2'd0;
                    tmo_d   = '0;
                end
            end
            REQ: begin
                mem_req   = 1'b1;
                mem_we    = store_q;
                mem_addr  = addr_q + BUS_WIDTH'(idx_q);
                mem_wdata = wdata_q[{idx_q, 3'b000} +: 8];
                if (mem_ack) begin
                    tmo_d   = '0;
                    capture = !store_q;
                    if (idx_q == last_idx(size_q)) begin
                        state_d   = DONE;
                        load_done = !store_q;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = ERR;
                    tmo_d   = '0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            ERR: begin
                err     = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tmo_q   <= tmo_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= BYTE;
            store_q <= 1'b0;
            sx_q    <= 1'b0;
            raw_q   <= '0;
            rdata_q <= '0;
        end else begin
            if (state_q == IDLE && start) begin
                addr_q  <= address;
                wdata_q <= wdata;
                size_q  <= mem_size;
                store_q <= is_store;
                sx_q    <= sz_ex;
                raw_q   <= '0;
            end
            if (capture)
                raw_q <= raw_merged;
            // rdata only moves when a load finishes, so errors and stores leave it intact.
            if (load_done)
                rdata_q <= ext_data;
        end
    end

    assign busy      = (state_q != IDLE);
    assign rdata     = rdata_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: byte memory responder, beat/response scoreboards.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start, is_store, sz_ex;
    logic [W-1:0] address, wdata;
    logic [1:0]   mem_size;
    logic         busy, done, err;
    logic [W-1:0] rdata;
    logic         mem_req, mem_we;
    logic [W-1:0] mem_addr;
    logic [7:0]   mem_wdata, mem_rdata;
    logic         mem_ack;
    lsu_state_t   state_dbg;

    logic [7:0]   mem [0:255];
    int           ack_delay, wcnt, cyc, start_cyc;
    logic         ack_en;
    int           n_cmp, n_bad;

    // beat: {we, addr, wdata}; resp: {done, err, cycle, rdata}
    logic [40:0]  beat_q[$];
    logic [41:0]  resp_q[$];

    load_store_unit dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_store  (is_store),
        .address   (address),
        .wdata     (wdata),
        .mem_size  (mem_size),
        .sz_ex     (sz_ex),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst && mem_req && mem_ack && mem_we)
            mem[mem_addr[7:0]] = mem_wdata;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- memory responder + monitor ----------------
    always @(negedge clk) begin
        if (rst || !mem_req) begin
            mem_ack = 1'b0;
            wcnt    = 0;
        end else begin
            if (mem_ack)
                wcnt = 0;
            if (ack_en && wcnt >= ack_delay) begin
                mem_ack = 1'b1;
            end else begin
                mem_ack = 1'b0;
                wcnt    = wcnt + 1;
            end
        end
        mem_rdata = mem[mem_addr[7:0]];

        if (!rst && mem_req) begin
            if (beat_q.size() == 0) begin
                if (mem_ack) check("beat_unexpected", 64'(mem_addr), 64'hFFFF_FFFF_FFFF_FFFF);
            end else if (mem_ack) begin
                check("beat", 64'({mem_we, mem_addr, mem_wdata}), 64'(beat_q.pop_front()));
            end else begin
                check("beat_hold", 64'({mem_we, mem_addr, mem_wdata}), 64'(beat_q[0]));
            end
        end

        if (!rst && (done || err)) begin
            if (resp_q.size() == 0)
                check("resp_unexpected", 64'({done, err, rdata}), 64'h0);
            else
                check("resp", 64'({done, err, 8'(cyc - start_cyc), rdata}), 64'(resp_q.pop_front()));
        end
    end

    // ---------------- driver ----------------
    task automatic push_beat(input logic we, input logic [31:0] a, input logic [7:0] d);
        beat_q.push_back({we, a, d});
    endtask

    task automatic push_resp(input logic d, input logic e, input logic [7:0] c, input logic [31:0] r);
        resp_q.push_back({d, e, c, r});
    endtask

    task automatic do_access(input logic st, input logic [31:0] a, input logic [31:0] wd,
                             input logic [1:0] sz, input logic sx);
        logic fin;
        @(negedge clk);
        start = 1'b1; is_store = st; address = a; wdata = wd; mem_size = sz; sz_ex = sx;
        start_cyc = cyc;
        @(posedge clk);
        #1 start = 1'b0;
        fin = 1'b0;
        for (int i = 0; i < 64 && !fin; i++) begin
            @(negedge clk);
            if (done || err) fin = 1'b1;
        end
        if (!fin) begin
            n_cmp++;
            n_bad++;
            $display("FAIL access_timeout: got no done/err expected one within 64 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0; start_cyc = 0;
        ack_delay = 0; ack_en = 1'b1; wcnt = 0;
        rst = 1'b1; start = 1'b0; is_store = 1'b0; address = '0; wdata = '0;
        mem_size = BYTE; sz_ex = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h20] = 8'h34; mem[8'h21] = 8'hF2; mem[8'h05] = 8'h9C;
        mem[8'h22] = 8'h11; mem[8'h23] = 8'h22; mem[8'h24] = 8'h33; mem[8'h25] = 8'h44;
        mem[8'h32] = 8'hAB;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_state", 64'(state_dbg), 64'(IDLE));
        check("rst_ctl", 64'({busy, done, err, mem_req, mem_we}), 64'h0);
        check("rst_bus", 64'({mem_addr, mem_wdata}), 64'h0);
        check("rst_rdata", 64'(rdata), 64'h0);
        rst = 1'b0;

        // word store, zero-wait: D4,C3,B2,A1 at 0x10..0x13, done in cycle 5
        push_beat(1, 32'h10, 8'hD4); push_beat(1, 32'h11, 8'hC3);
        push_beat(1, 32'h12, 8'hB2); push_beat(1, 32'h13, 8'hA1);
        push_resp(1, 0, 8'd5, 32'h0);
        do_access(1'b1, 32'h10, 32'hA1B2C3D4, WORD, 1'b0);
        check("store_mem", 64'({mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]}), 64'hA1B2C3D4);

        // half loads, sign and zero extended
        push_beat(0, 32'h20, 8'h00); push_beat(0, 32'h21, 8'h00);
        push_resp(1, 0, 8'd3, 32'hFFFFF234);
        do_access(1'b0, 32'h20, 32'h0, HALF_WORD, 1'b1);
        push_beat(0, 32'h20, 8'h00); push_beat(0, 32'h21, 8'h00);
        push_resp(1, 0, 8'd3, 32'h0000F234);
        do_access(1'b0, 32'h20, 32'h0, HALF_WORD, 1'b0);

        // byte load with 3 wait cycles: request held stable, done in cycle 5
        ack_delay = 3;
        push_beat(0, 32'h05, 8'h00);
        push_resp(1, 0, 8'd5, 32'hFFFFFF9C);
        do_access(1'b0, 32'h05, 32'h0, BYTE, 1'b1);
        ack_delay = 0;

        // no ack: err after 16 request cycles, rdata untouched
        ack_en = 1'b0;
        push_resp(0, 1, 8'd17, 32'hFFFFFF9C);
        do_access(1'b0, 32'h40, 32'h0, BYTE, 1'b0);
        ack_en = 1'b1;
        check("tmo_busy", 64'(busy), 64'h0);
        check("tmo_rdata", 64'(rdata), 64'hFFFFFF9C);

        // misaligned word load at 0x22
`ifdef LSU_ALIGN_CHECK_EN
        push_resp(0, 1, 8'd1, 32'hFFFFFF9C);
`else
        push_beat(0, 32'h22, 8'h00); push_beat(0, 32'h23, 8'h00);
        push_beat(0, 32'h24, 8'h00); push_beat(0, 32'h25, 8'h00);
        push_resp(1, 0, 8'd5, 32'h44332211);
`endif
        do_access(1'b0, 32'h22, 32'h0, WORD, 1'b1);

        // reserved size code: err in cycle 1, no request
        push_resp(0, 1, 8'd1, rdata);
        do_access(1'b0, 32'h60, 32'h0, 2'b11, 1'b0);

        // reset after the second byte of a word store
        push_beat(1, 32'h30, 8'h88); push_beat(1, 32'h31, 8'h77);
        @(negedge clk);
        start = 1'b1; is_store = 1'b1; address = 32'h30; wdata = 32'h55667788;
        mem_size = WORD; sz_ex = 1'b0; start_cyc = cyc;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("rst_mid_req", 64'({mem_req, busy, done, err}), 64'h0);
        check("rst_mid_state", 64'(state_dbg), 64'(IDLE));
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mid_mem", 64'({mem[8'h32], mem[8'h31], mem[8'h30]}), 64'hAB7788);
        check("rst_mid_rdata", 64'(rdata), 64'h0);

        // next access after reset is accepted normally
        push_beat(1, 32'h50, 8'hEE);
        push_resp(1, 0, 8'd2, 32'h0);
        do_access(1'b1, 32'h50, 32'h000000EE, BYTE, 1'b0);
        check("post_rst_mem", 64'(mem[8'h50]), 64'hEE);

        repeat (2) @(posedge clk);
        check("beat_q_empty", 64'(beat_q.size()), 64'h0);
        check("resp_q_empty", 64'(resp_q.size()), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter BUS_WIDTH, default 32, SHALL set the width of the core-side address and data buses.
REQ-002 Parameter ACK_TIMEOUT, default 16, SHALL set the number of consecutive un-acked request cycles that abort an access.
REQ-003 Port clk, input, 1: the single clock; all state SHALL update on posedge clk.
REQ-004 Port rst, input, 1: reset, asynchronous and active-high.
REQ-005 Core-side inputs SHALL be:
- start, 1: access request.
- is_store, 1: 1 = store, 0 = load.
- address, BUS_WIDTH: byte address.
- wdata, BUS_WIDTH: store data.
- mem_size, 2: 00 = byte, 01 = half, 10 = word.
- sz_ex, 1: 1 = sign-extend, 0 = zero-extend.
REQ-006 Core-side outputs SHALL be:
- busy, 1: access in progress.
- done, 1: completion pulse.
- err, 1: abort pulse.
- rdata, BUS_WIDTH: load result.
REQ-007 Memory-side byte initiator ports SHALL be:
- Outputs: mem_req 1, mem_we 1, mem_addr BUS_WIDTH, mem_wdata 8.
- Inputs: mem_rdata 8, mem_ack 1.

Function
REQ-008 FSM SHALL have states IDLE, REQ, DONE and ERR.
REQ-009 IDLE with start=1 SHALL latch address, wdata, mem_size, is_store and sz_ex, and SHALL move to REQ with the byte index cleared to 0.
REQ-010 start SHALL be ignored outside IDLE.
REQ-011 In REQ the block SHALL drive the following:
- mem_req=1 and mem_we=is_store.
- mem_addr = latched address + byte index.
- mem_wdata = latched wdata byte [8*idx+7:8*idx].
REQ-012 A byte transfer SHALL complete in the cycle where mem_req && mem_ack; a load SHALL capture mem_rdata into byte lane idx on that edge.
REQ-013 Byte count SHALL be 4 for word, 2 for half and 1 for byte. Bytes SHALL go in little-endian order: address, then +1, +2, +3.
REQ-014 When the last byte is acked, the FSM SHALL go to DONE. Otherwise it SHALL stay in REQ with idx+1 and keep mem_req asserted with no idle cycle.
REQ-015 In DONE, done=1 for exactly one cycle. For a load, rdata SHALL then hold the extended result. The FSM SHALL then return to IDLE.
REQ-016 Loads SHALL extend as follows:
- Half and byte results: sz_ex=1 replicates bit 15 or bit 7; sz_ex=0 fills with zeros.
- Word loads ignore sz_ex.
REQ-017 rdata SHALL hold its value until the next load completes; stores SHALL leave rdata unchanged.
REQ-018 mem_size=11 at start SHALL go straight to ERR with no memory request issued.
REQ-019 A timeout counter SHALL clear on each ack. After ACK_TIMEOUT consecutive REQ cycles without ack, the block SHALL drop mem_req and go to ERR.
REQ-020 In ERR, err=1 for exactly one cycle, then the FSM SHALL return to IDLE. rdata SHALL be unchanged, and bytes already stored SHALL NOT be undone.
REQ-021 busy SHALL be 1 in REQ, DONE and ERR, and 0 in IDLE.
REQ-022 Minimum latency: start at cycle 0 with zero-wait ack SHALL give mem_req in cycles 1..N and done in cycle N+1.

Reset
REQ-023 rst=1 SHALL immediately, without waiting for clk, force the following:
- FSM to IDLE.
- mem_req, mem_we, busy, done and err to 0.
- mem_addr, mem_wdata and rdata to 0.
- byte index and timeout counter to 0.
REQ-024 Reset asserted mid-access SHALL abandon the access with no done or err pulse.

Configuration
REQ-025 With LSU_ALIGN_CHECK_EN defined, half accesses with address[0]=1 and word accesses with address[1:0]!=0 SHALL go to ERR without issuing mem_req.
REQ-026 Without LSU_ALIGN_CHECK_EN, misaligned accesses SHALL proceed byte-by-byte per REQ-013.

Structure
REQ-027 A shared package SHALL hold the following:
- The mem_size encodings WORD=10, HALF_WORD=01 and BYTE=00, identical to those used by the data memory.
- The FSM state typedef.
- The BUS_WIDTH default.
REQ-028 The load extension logic SHALL be a sub-module named lsu_extend, taking raw data, mem_size and sz_ex and producing the extended word.

Verification
REQ-029 Word store, address=0x10, wdata=0xA1B2C3D4, zero-wait ack SHALL give mem_addr 0x10..0x13 with mem_wdata D4, C3, B2, A1, and done in cycle 5.
REQ-030 Half load with sign extension, address=0x20, memory bytes 0x20=34 and 0x21=F2, SHALL give rdata=0xFFFFF234; the same access with sz_ex=0 SHALL give 0x0000F234.
REQ-031 Byte load, address=0x05, mem_ack delayed 3 cycles, SHALL hold mem_req and mem_addr=0x05 stable throughout and give done in cycle 5.
REQ-032 mem_ack never asserted SHALL give err after 16 REQ cycles, followed by busy=0 and rdata unchanged.
REQ-033 With LSU_ALIGN_CHECK_EN, a word load at 0x22 SHALL give an err pulse in cycle 1 with mem_req never asserted. Without the macro, the same access SHALL complete with 4 byte reads.
REQ-034 rst asserted after the 2nd byte of a word store SHALL drop mem_req combinationally, with no done or err pulse, and the next start SHALL be accepted normally.
